// File: rtl/axi_arb_pkg.sv
// Shared types and constants for the instruction-side AXI read arbiter.
package axi_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2
    } arb_state_e;

    localparam logic OWN_FETCH = 1'b0;
    localparam logic OWN_LOAD  = 1'b1;

    localparam logic [1:0] AXI_BURST_FIXED = 2'b00;
    localparam logic [1:0] AXI_BURST_INCR  = 2'b01;
    localparam logic [1:0] AXI_BURST_WRAP  = 2'b10;

    localparam logic [2:0] AXI_SIZE_1B = 3'd0;
    localparam logic [2:0] AXI_SIZE_2B = 3'd1;
    localparam logic [2:0] AXI_SIZE_4B = 3'd2;
    localparam logic [2:0] AXI_SIZE_8B = 3'd3;

endpackage

// File: rtl/arb_pick.sv
// Two-way request picker. req[0] = fetch, req[1] = load.
// ARB_ROUND_ROBIN_EN defined: simultaneous requests go to the side not granted last.
// ARB_ROUND_ROBIN_EN undefined: fixed priority, load over fetch.
module arb_pick
    import axi_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic [1:0] grant
);

`ifndef ARB_ROUND_ROBIN_EN
    // Fixed priority ignores history; keep the input visibly consumed.
    logic unused_last_grant_s;
    assign unused_last_grant_s = last_grant;
`endif

    // One-hot grant selection under the configured policy
    always_comb begin
        grant = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
        if (req == 2'b11) begin
            if (last_grant == OWN_FETCH) begin
                grant = 2'b10;
            end else begin
                grant = 2'b01;
            end
        end else begin
            grant = req;
        end
`else
        if (req[1]) begin
            grant = 2'b10;
        end else if (req[0]) begin
            grant = 2'b01;
        end else begin
            grant = 2'b00;
        end
`endif
    end

endmodule

// File: rtl/axi_rd_arbiter.sv
// Shares one AXI read port between instruction fetch (requester 0) and the
// load unit (requester 1). One transaction at a time; fetch data still in
// flight when a redirect arrives is consumed from memory and dropped.
// Arbitration policy selected by macro ARB_ROUND_ROBIN_EN (see arb_pick).
module axi_rd_arbiter
    import axi_arb_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 64
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch requester
    input  logic              f_arvalid,
    output logic              f_arready,
    input  logic [ADDR_W-1:0] f_araddr,
    input  logic [7:0]        f_arlen,
    input  logic [2:0]        f_arsize,
    input  logic [1:0]        f_arburst,
    output logic              f_rvalid,
    input  logic              f_rready,
    output logic [DATA_W-1:0] f_rdata,
    output logic              f_rlast,
    // load requester
    input  logic              l_arvalid,
    output logic              l_arready,
    input  logic [ADDR_W-1:0] l_araddr,
    input  logic [7:0]        l_arlen,
    input  logic [2:0]        l_arsize,
    input  logic [1:0]        l_arburst,
    output logic              l_rvalid,
    input  logic              l_rready,
    output logic [DATA_W-1:0] l_rdata,
    output logic              l_rlast,
    // redirect
    input  logic              flush,
    // memory side
    output logic              m_arvalid,
    input  logic              m_arready,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    input  logic              m_rvalid,
    output logic              m_rready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic              m_rlast,
    // status
    output logic              owner,
    output logic              busy,
    output logic              len_err
);

    arb_state_e        state_r;
    arb_state_e        next_state_s;
    logic              owner_r;
    logic              last_grant_r;
    logic              discard_r;
    logic              len_err_r;
    logic [7:0]        beat_cnt_r;
    logic [ADDR_W-1:0] ar_addr_r;
    logic [7:0]        ar_len_r;
    logic [2:0]        ar_size_r;
    logic [1:0]        ar_burst_r;

    logic [1:0]        req_s;
    logic [1:0]        grant_s;
    logic              grant_any_s;
    logic              drop_s;
    logic              m_rready_s;
    logic              beat_s;

    // A fetch is never granted while a redirect is being signalled.
    assign req_s       = {l_arvalid, f_arvalid & ~flush};
    assign grant_any_s = (state_r == IDLE) && (grant_s != 2'b00);

    arb_pick u_pick (
        .req        (req_s),
        .last_grant (last_grant_r),
        .grant      (grant_s)
    );

    // A redirect in the same cycle as a fetch beat already drops that beat.
    assign drop_s = (owner_r == OWN_FETCH) && (discard_r || flush);
    assign beat_s = (state_r == DATA) && m_rvalid && m_rready_s;

    assign m_arvalid = (state_r == ADDR);
    assign m_araddr  = ar_addr_r;
    assign m_arlen   = ar_len_r;
    assign m_arsize  = ar_size_r;
    assign m_arburst = ar_burst_r;
    assign m_rready  = m_rready_s;
    assign owner     = owner_r;
    assign busy      = (state_r != IDLE);
    assign len_err   = len_err_r;

    // Next-state, grant handshake and R-channel routing
    always_comb begin
        next_state_s = state_r;
        f_arready    = 1'b0;
        l_arready    = 1'b0;
        m_rready_s   = 1'b0;
        f_rvalid     = 1'b0;
        l_rvalid     = 1'b0;
        case (state_r)
            IDLE: begin
                if (rst_n) begin
                    f_arready = grant_s[0];
                    l_arready = grant_s[1];
                    if (grant_s != 2'b00) begin
                        next_state_s = ADDR;
                    end else begin
                        next_state_s = IDLE;
                    end
                end else begin
                    next_state_s = IDLE;
                end
            end
            ADDR: begin
                if (m_arready) begin
                    next_state_s = DATA;
                end else begin
                    next_state_s = ADDR;
                end
            end
            DATA: begin
                if (drop_s) begin
                    m_rready_s = 1'b1;
                end else if (owner_r == OWN_LOAD) begin
                    m_rready_s = l_rready;
                    l_rvalid   = m_rvalid;
                end else begin
                    m_rready_s = f_rready;
                    f_rvalid   = m_rvalid;
                end
                if (m_rvalid && m_rready_s && m_rlast) begin
                    next_state_s = IDLE;
                end else begin
                    next_state_s = DATA;
                end
            end
            default: begin
                next_state_s = IDLE;
            end
        endcase
    end

    // Read payload goes only to the side currently presenting a valid beat
    always_comb begin
        f_rdata = {DATA_W{1'b0}};
        l_rdata = {DATA_W{1'b0}};
        f_rlast = 1'b0;
        l_rlast = 1'b0;
        if (f_rvalid) begin
            f_rdata = m_rdata;
            f_rlast = m_rlast;
        end else begin
            f_rlast = 1'b0;
        end
        if (l_rvalid) begin
            l_rdata = m_rdata;
            l_rlast = m_rlast;
        end else begin
            l_rlast = 1'b0;
        end
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Latch the granted request's payload and ownership
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            owner_r      <= OWN_FETCH;
            last_grant_r <= OWN_FETCH;
            ar_addr_r    <= {ADDR_W{1'b0}};
            ar_len_r     <= 8'd0;
            ar_size_r    <= 3'd0;
            ar_burst_r   <= 2'd0;
        end else if (grant_any_s) begin
            owner_r      <= grant_s[1];
            last_grant_r <= grant_s[1];
            if (grant_s[1]) begin
                ar_addr_r  <= l_araddr;
                ar_len_r   <= l_arlen;
                ar_size_r  <= l_arsize;
                ar_burst_r <= l_arburst;
            end else begin
                ar_addr_r  <= f_araddr;
                ar_len_r   <= f_arlen;
                ar_size_r  <= f_arsize;
                ar_burst_r <= f_arburst;
            end
        end else begin
            owner_r <= owner_r;
        end
    end

    // Beat counter and sticky burst-length error
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt_r <= 8'd0;
            len_err_r  <= 1'b0;
        end else if (grant_any_s) begin
            beat_cnt_r <= 8'd0;
        end else if (beat_s) begin
            beat_cnt_r <= beat_cnt_r + 8'd1;
            if (m_rlast && (beat_cnt_r != ar_len_r)) begin
                len_err_r <= 1'b1;
            end else if (!m_rlast && (beat_cnt_r > ar_len_r)) begin
                len_err_r <= 1'b1;
            end else begin
                len_err_r <= len_err_r;
            end
        end else begin
            beat_cnt_r <= beat_cnt_r;
        end
    end

    // Discard flag: a redirect kills the outstanding fetch until it drains
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            discard_r <= 1'b0;
        end else if (state_r == IDLE || next_state_s == IDLE) begin
            discard_r <= 1'b0;
        end else if (flush && (owner_r == OWN_FETCH)) begin
            discard_r <= 1'b1;
        end else begin
            discard_r <= discard_r;
        end
    end

endmodule

// File: tb/tb_axi_rd_arbiter.sv
// Directed bench for axi_rd_arbiter with a queue-based scoreboard.
// Expected AR payloads and forwarded R beats are queued by the stimulus; a
// negedge monitor pops and compares on every handshake.
module tb_axi_rd_arbiter;
    import axi_arb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        f_arvalid, f_arready, f_rvalid, f_rready, f_rlast;
    logic [31:0] f_araddr;
    logic [7:0]  f_arlen;
    logic [2:0]  f_arsize;
    logic [1:0]  f_arburst;
    logic [63:0] f_rdata;
    logic        l_arvalid, l_arready, l_rvalid, l_rready, l_rlast;
    logic [31:0] l_araddr;
    logic [7:0]  l_arlen;
    logic [2:0]  l_arsize;
    logic [1:0]  l_arburst;
    logic [63:0] l_rdata;
    logic        flush;
    logic        m_arvalid, m_arready, m_rvalid, m_rready, m_rlast;
    logic [31:0] m_araddr;
    logic [7:0]  m_arlen;
    logic [2:0]  m_arsize;
    logic [1:0]  m_arburst;
    logic [63:0] m_rdata;
    logic        owner, busy, len_err;

    typedef struct packed {
        logic [31:0] addr;
        logic [7:0]  len;
        logic [2:0]  size;
        logic [1:0]  burst;
    } ar_t;
    typedef struct packed {
        logic [63:0] data;
        logic        last;
    } r_t;

    ar_t ar_q[$];
    r_t  fq[$];
    r_t  lq[$];
    ar_t exp_ar;
    r_t  exp_r;
    int  n_cmp = 0;
    int  n_err = 0;

    axi_rd_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .f_arvalid(f_arvalid), .f_arready(f_arready), .f_araddr(f_araddr),
        .f_arlen(f_arlen), .f_arsize(f_arsize), .f_arburst(f_arburst),
        .f_rvalid(f_rvalid), .f_rready(f_rready), .f_rdata(f_rdata), .f_rlast(f_rlast),
        .l_arvalid(l_arvalid), .l_arready(l_arready), .l_araddr(l_araddr),
        .l_arlen(l_arlen), .l_arsize(l_arsize), .l_arburst(l_arburst),
        .l_rvalid(l_rvalid), .l_rready(l_rready), .l_rdata(l_rdata), .l_rlast(l_rlast),
        .flush(flush),
        .m_arvalid(m_arvalid), .m_arready(m_arready), .m_araddr(m_araddr),
        .m_arlen(m_arlen), .m_arsize(m_arsize), .m_arburst(m_arburst),
        .m_rvalid(m_rvalid), .m_rready(m_rready), .m_rdata(m_rdata), .m_rlast(m_rlast),
        .owner(owner), .busy(busy), .len_err(len_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Scoreboard monitor: compare every AR and forwarded R handshake
    always @(negedge clk) begin
        if (m_arvalid && m_arready) begin
            if (ar_q.size() == 0) begin
                chk("ar_unexpected", 64'd1, 64'd0);
            end else begin
                exp_ar = ar_q.pop_front();
                chk("ar_payload", {19'd0, m_araddr, m_arlen, m_arsize, m_arburst}, {19'd0, exp_ar});
            end
        end
        if (f_rvalid && f_rready) begin
            if (fq.size() == 0) begin
                chk("f_beat_unexpected", 64'd1, 64'd0);
            end else begin
                exp_r = fq.pop_front();
                chk("f_rdata", f_rdata, exp_r.data);
                chk("f_rlast", {63'd0, f_rlast}, {63'd0, exp_r.last});
            end
        end
        if (l_rvalid && l_rready) begin
            if (lq.size() == 0) begin
                chk("l_beat_unexpected", 64'd1, 64'd0);
            end else begin
                exp_r = lq.pop_front();
                chk("l_rdata", l_rdata, exp_r.data);
                chk("l_rlast", {63'd0, l_rlast}, {63'd0, exp_r.last});
            end
        end
    end

    task automatic set_req(input bit side, input logic [31:0] a, input logic [7:0] len);
        if (side) begin
            l_arvalid = 1'b1; l_araddr = a; l_arlen = len; l_arsize = 3'd3; l_arburst = 2'b01;
        end else begin
            f_arvalid = 1'b1; f_araddr = a; f_arlen = len; f_arsize = 3'd3; f_arburst = 2'b01;
        end
    endtask

    // Expect 'side' to be granted this cycle; called just after a posedge.
    task automatic grant_step(input bit side, input logic [31:0] a, input logic [7:0] len);
        ar_q.push_back('{a, len, 3'd3, 2'b01});
        @(negedge clk);
        chk(side ? "l_arready" : "f_arready", {63'd0, side ? l_arready : f_arready}, 64'd1);
        chk("other_arready", {63'd0, side ? f_arready : l_arready}, 64'd0);
        @(posedge clk); #1;
        if (side) l_arvalid = 1'b0; else f_arvalid = 1'b0;
    endtask

    task automatic issue(input bit side, input logic [31:0] a, input logic [7:0] len);
        set_req(side, a, len);
        grant_step(side, a, len);
    endtask

    task automatic ar_accept(input bit side, input logic [31:0] a, input int stall);
        int n;
        n = 0;
        m_arready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            @(negedge clk);
            chk("ar_hold_valid", {63'd0, m_arvalid}, 64'd1);
            chk("ar_hold_addr", {32'd0, m_araddr}, {32'd0, a});
            chk("no_r_before_ar", {61'd0, f_rvalid, l_rvalid, m_rready}, 64'd0);
            @(posedge clk); #1;
        end
        m_arready = 1'b1;
        @(negedge clk);
        while (!m_arvalid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("ar_latency", n, 64'd0);
        chk("owner", {63'd0, owner}, {63'd0, side});
        chk("busy_ar", {63'd0, busy}, 64'd1);
        @(posedge clk); #1;
        m_arready = 1'b0;
    endtask

    task automatic beat(input bit side, input logic [63:0] d, input bit last, input bit fwd);
        int n;
        n = 0;
        m_rvalid = 1'b1; m_rdata = d; m_rlast = last;
        if (fwd) begin
            if (side) lq.push_back('{d, last}); else fq.push_back('{d, last});
        end
        @(negedge clk);
        while (!m_rready && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("m_rready_wait", {63'd0, m_rready}, 64'd1);
        if (!fwd) begin
            chk("dropped_beat", {62'd0, f_rvalid, l_rvalid}, 64'd0);
        end
        @(posedge clk); #1;
        m_rvalid = 1'b0; m_rlast = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // Directed stimulus
    initial begin
        f_arvalid = 1'b0; f_araddr = 32'd0; f_arlen = 8'd0; f_arsize = 3'd0; f_arburst = 2'd0;
        l_arvalid = 1'b0; l_araddr = 32'd0; l_arlen = 8'd0; l_arsize = 3'd0; l_arburst = 2'd0;
        f_rready = 1'b1; l_rready = 1'b1; flush = 1'b0;
        m_arready = 1'b0; m_rvalid = 1'b0; m_rdata = 64'd0; m_rlast = 1'b0;

        // reset values, request ignored while in reset
        repeat (2) @(posedge clk);
        f_arvalid = 1'b1;
        @(negedge clk);
        chk("rst_status", {61'd0, owner, busy, len_err}, 64'd0);
        chk("rst_ready", {60'd0, f_arready, l_arready, m_arvalid, m_rready}, 64'd0);
        chk("rst_rvalid", {62'd0, f_rvalid, l_rvalid}, 64'd0);
        @(posedge clk); #1;
        f_arvalid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // single-beat fetch
        issue(1'b0, 32'h100, 8'd0);
        ar_accept(1'b0, 32'h100, 0);
        beat(1'b0, 64'hAAAA_BBBB_CCCC_DDDD, 1'b1, 1'b1);
        @(negedge clk);
        chk("busy_after_fetch", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        // simultaneous requests: load first, then policy decides
        set_req(1'b0, 32'h300, 8'd0);
        set_req(1'b1, 32'h200, 8'd0);
        grant_step(1'b1, 32'h200, 8'd0);
        set_req(1'b1, 32'h240, 8'd0);
        ar_accept(1'b1, 32'h200, 0);
        beat(1'b1, 64'h1111_0000_0000_0001, 1'b1, 1'b1);
`ifdef ARB_ROUND_ROBIN_EN
        grant_step(1'b0, 32'h300, 8'd0);
        ar_accept(1'b0, 32'h300, 0);
        beat(1'b0, 64'h2222_0000_0000_0002, 1'b1, 1'b1);
        grant_step(1'b1, 32'h240, 8'd0);
        ar_accept(1'b1, 32'h240, 0);
        beat(1'b1, 64'h3333_0000_0000_0003, 1'b1, 1'b1);
`else
        grant_step(1'b1, 32'h240, 8'd0);
        ar_accept(1'b1, 32'h240, 0);
        beat(1'b1, 64'h3333_0000_0000_0003, 1'b1, 1'b1);
        grant_step(1'b0, 32'h300, 8'd0);
        ar_accept(1'b0, 32'h300, 0);
        beat(1'b0, 64'h2222_0000_0000_0002, 1'b1, 1'b1);
`endif

        // fetch burst killed by redirect after two beats
        issue(1'b0, 32'h400, 8'd3);
        ar_accept(1'b0, 32'h400, 0);
        beat(1'b0, 64'h4000_0000_0000_0000, 1'b0, 1'b1);
        beat(1'b0, 64'h4000_0000_0000_0001, 1'b0, 1'b1);
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        f_rready = 1'b0;
        beat(1'b0, 64'h4000_0000_0000_0002, 1'b0, 1'b0);
        beat(1'b0, 64'h4000_0000_0000_0003, 1'b1, 1'b0);
        f_rready = 1'b1;
        @(negedge clk);
        chk("busy_after_discard", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;
        issue(1'b0, 32'h440, 8'd0);
        ar_accept(1'b0, 32'h440, 0);
        beat(1'b0, 64'h4400_0000_0000_0000, 1'b1, 1'b1);

        // redirect in the same cycle as the last fetch beat
        issue(1'b0, 32'h480, 8'd0);
        ar_accept(1'b0, 32'h480, 0);
        flush = 1'b1;
        beat(1'b0, 64'h4800_0000_0000_0000, 1'b1, 1'b0);
        flush = 1'b0;
        @(negedge clk);
        chk("busy_after_flush_last", {63'd0, busy}, 64'd0);
        @(posedge clk); #1;

        // fetch not granted while flush is high
        set_req(1'b0, 32'h500, 8'd0);
        flush = 1'b1;
        @(negedge clk);
        chk("flush_blocks_fetch", {62'd0, f_arready, busy}, 64'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        grant_step(1'b0, 32'h500, 8'd0);
        ar_accept(1'b0, 32'h500, 0);
        beat(1'b0, 64'h5000_0000_0000_0000, 1'b1, 1'b1);

        // AR stall with memory asserting rvalid early; flush ignored for load
        issue(1'b1, 32'h600, 8'd1);
        m_rvalid = 1'b1; m_rdata = 64'hDEAD_DEAD_DEAD_DEAD;
        ar_accept(1'b1, 32'h600, 5);
        m_rvalid = 1'b0;
        beat(1'b1, 64'h6000_0000_0000_0000, 1'b0, 1'b1);
        flush = 1'b1;
        beat(1'b1, 64'h6000_0000_0000_0001, 1'b1, 1'b1);
        flush = 1'b0;

        // owner back-pressure
        issue(1'b1, 32'h680, 8'd0);
        ar_accept(1'b1, 32'h680, 0);
        l_rready = 1'b0;
        m_rvalid = 1'b1; m_rdata = 64'h6800_0000_0000_00AA; m_rlast = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("bp_m_rready", {63'd0, m_rready}, 64'd0);
            chk("bp_l_rvalid", {63'd0, l_rvalid}, 64'd1);
            @(posedge clk); #1;
        end
        l_rready = 1'b1;
        beat(1'b1, 64'h6800_0000_0000_00AA, 1'b1, 1'b1);
        @(negedge clk);
        chk("bp_no_len_err", {62'd0, len_err, busy}, 64'd0);
        @(posedge clk); #1;

        // early rlast sets sticky len_err
        issue(1'b1, 32'h700, 8'd3);
        ar_accept(1'b1, 32'h700, 0);
        beat(1'b1, 64'h7000_0000_0000_0000, 1'b0, 1'b1);
        beat(1'b1, 64'h7000_0000_0000_0001, 1'b1, 1'b1);
        @(negedge clk);
        chk("len_err_set", {62'd0, len_err, busy}, 64'd2);
        @(posedge clk); #1;
        issue(1'b0, 32'h780, 8'd0);
        ar_accept(1'b0, 32'h780, 0);
        beat(1'b0, 64'h7800_0000_0000_0000, 1'b1, 1'b1);
        @(negedge clk);
        chk("len_err_sticky", {63'd0, len_err}, 64'd1);
        @(posedge clk); #1;

        // reset mid-DATA clears everything at once
        issue(1'b1, 32'h800, 8'd1);
        ar_accept(1'b1, 32'h800, 0);
        m_rvalid = 1'b1;
        rst_n = 1'b0;
        #1;
        chk("midrst_status", {61'd0, owner, busy, len_err}, 64'd0);
        chk("midrst_ready", {59'd0, m_arvalid, m_rready, l_rvalid, f_rvalid, l_arready}, 64'd0);
        @(posedge clk); #1;
        m_rvalid = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        chk("ar_q_empty", ar_q.size(), 64'd0);
        chk("fq_empty", fq.size(), 64'd0);
        chk("lq_empty", lq.size(), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
